io_bus_arbiter: RTL

Round-robin arbiter that shares the 32-bit IO fabric output bus between several requesters. It grants one requester at a time and forwards that requester's accepted beats to a single registered output bus. It sits between the demo logic sources (sum, concat, gauge producers) and the `out_bus` pins. Ownership is released after a requester's last beat, when it withdraws, or on a burst-limit timeout.

---
 rtl/io_fabric_pkg.sv | 13 +
 rtl/io_bus_arbiter_rr_pick.sv | 27 ++
 rtl/io_bus_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/io_fabric_pkg.sv
// io_fabric_pkg: shared types, defaults and helpers for the IO fabric output-bus arbiter.
package io_fabric_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_e;
    localparam int NREQ_DEF = 4;
    localparam int DW_DEF = 32;
    localparam int MAX_BURST_DEF = 8;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after ptr_i wins, wrapping.
module rr_pick import io_fabric_pkg::*; #(
    parameter int N = NREQ_DEF,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        onehot_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o = IW'(j);
            end
        end
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin owner of the 32-bit IO output bus with registered forwarding.
// Optional burst-limit release compiled in with IO_ARB_BURST_LIMIT_EN.
module io_bus_arbiter import io_fabric_pkg::*; #(
    parameter int NREQ = NREQ_DEF,
    parameter int DW = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int IW = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [IW-1:0]      out_src,
    output logic               busy
);
    arb_state_e state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, ptr_next, pick_ptr, win_idx;
    logic [NREQ-1:0] gnt_q, gnt_d, win_oh;
    logic out_valid_q;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_src_q, out_src_d;
    logic accept, limit_hit, release_c, arb, win_any;
`ifdef IO_ARB_BURST_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        accept = state_q == GRANT && req[owner_q];
`ifdef IO_ARB_BURST_LIMIT_EN
        limit_hit = accept && cnt_q == 8'(MAX_BURST - 1);
`else
        limit_hit = 1'b0;
`endif
        release_c = state_q == GRANT && (!req[owner_q] || (accept && req_last[owner_q]) || limit_hit);
        ptr_next = owner_q == IW'(NREQ - 1) ? '0 : owner_q + IW'(1);
        // On release the new pointer is used immediately so the switch costs no idle cycle.
        pick_ptr = release_c ? ptr_next : ptr_q;
        arb = state_q == IDLE || release_c;
        state_d = arb ? (win_any ? GRANT : IDLE) : state_q;
        gnt_d = arb ? (win_any ? win_oh : '0) : gnt_q;
        owner_d = arb && win_any ? win_idx : owner_q;
        ptr_d = release_c ? ptr_next : ptr_q;
        out_data_d = accept ? req_data[owner_q*DW +: DW] : out_data_q;
        out_src_d = accept ? owner_q : out_src_q;
`ifdef IO_ARB_BURST_LIMIT_EN
        cnt_d = release_c ? 8'd0 : (accept && cnt_q != 8'(MAX_BURST)) ? cnt_q + 8'd1 : cnt_q;
`endif
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req_i(req),
        .ptr_i(pick_ptr),
        .onehot_o(win_oh),
        .idx_o(win_idx),
        .any_o(win_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            owner_q <= '0;
            gnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_src_q <= '0;
`ifdef IO_ARB_BURST_LIMIT_EN
            cnt_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            gnt_q <= gnt_d;
            out_valid_q <= accept;
            out_data_q <= out_data_d;
            out_src_q <= out_src_d;
`ifdef IO_ARB_BURST_LIMIT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign gnt = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_src = out_src_q;
    assign busy = state_q == GRANT;
endmodule
